// File: rtl/min_16_pkg.sv
// -----------------------------------------------------------------------------
// min_16_pkg
// Shared constants and types for the 16-way minimum finder.
//   MIN16_N_ELEM : number of candidates compared per evaluation
//   MIN16_IDX_W  : width of the winning-candidate index
//   MIN16_DEF_W  : default element width (cost value width)
//   min16_pair_t : (value, index) pair at the default element width
// -----------------------------------------------------------------------------
package min_16_pkg;

  localparam int MIN16_N_ELEM = 16;
  localparam int MIN16_IDX_W  = 4;
  localparam int MIN16_DEF_W  = 14;

  typedef struct packed {
    logic [MIN16_DEF_W-1:0] val;
    logic [MIN16_IDX_W-1:0] idx;
  } min16_pair_t;

  // Index carried by leaf i of the tree.
  function automatic logic [MIN16_IDX_W-1:0] min16_leaf_idx(input int i);
    return MIN16_IDX_W'(i);
  endfunction

endpackage

// File: rtl/min_16_min_2_sel.sv
// -----------------------------------------------------------------------------
// min_2_sel
// One compare-select node of the minimum tree: forwards the smaller of two
// (value, index) pairs. Side a always holds the lower-index subtree, so equal
// values resolve to side a.
// Ports:
//   i_a_val, i_a_idx : pair from the lower-index subtree
//   i_b_val, i_b_idx : pair from the higher-index subtree
//   o_val, o_idx     : winning pair
// -----------------------------------------------------------------------------
module min_2_sel
  import min_16_pkg::*;
#(
  parameter int VAL_W = MIN16_DEF_W
) (
  input  logic [VAL_W-1:0]       i_a_val,
  input  logic [MIN16_IDX_W-1:0] i_a_idx,
  input  logic [VAL_W-1:0]       i_b_val,
  input  logic [MIN16_IDX_W-1:0] i_b_idx,
  output logic [VAL_W-1:0]       o_val,
  output logic [MIN16_IDX_W-1:0] o_idx
);

  logic w_take_b;

  // NOTE: strictly-less-than, so a tie keeps side a (the lower index); using
  // <= here would silently flip the tie-break at every node.
  assign w_take_b = (i_b_val < i_a_val);
  assign o_val    = w_take_b ? i_b_val : i_a_val;
  assign o_idx    = w_take_b ? i_b_idx : i_a_idx;

endmodule

// File: rtl/min_16.sv
// -----------------------------------------------------------------------------
// min_16
// Minimum finder over 16 packed unsigned elements with registered outputs.
// Reports the smallest value and the lowest index holding it.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : min_array holds a set to evaluate this cycle
//   min_array : 16 elements, element i at [i*W +: W]
//   min       : smallest element value (registered)
//   min_index : index of the smallest element (registered)
//   out_valid : min/min_index belong to an accepted set
// Configuration:
//   MIN_16_PIPE_EN : when defined, registers the four level-2 survivors,
//                    giving a latency of 2 instead of 1.
// -----------------------------------------------------------------------------
module min_16
  import min_16_pkg::*;
#(
  parameter int ELEMENT_BIT_DEPTH = MIN16_DEF_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic [ELEMENT_BIT_DEPTH*MIN16_N_ELEM-1:0] min_array,
  output logic [ELEMENT_BIT_DEPTH-1:0]            min,
  output logic [MIN16_IDX_W-1:0]                  min_index,
  output logic                                    out_valid
);

  localparam int W = ELEMENT_BIT_DEPTH;

  // Tree levels: 16 leaves -> 8 -> 4 -> 2 -> 1. Each node carries the full
  // 4-bit index; the upper bits are constant within a subtree and fold away.
  logic [W-1:0]             w_l0_val    [16];
  logic [MIN16_IDX_W-1:0]   w_l0_idx    [16];
  logic [W-1:0]             w_l1_val    [8];
  logic [MIN16_IDX_W-1:0]   w_l1_idx    [8];
  logic [W-1:0]             w_l2_val    [4];
  logic [MIN16_IDX_W-1:0]   w_l2_idx    [4];
  logic [W-1:0]             w_l3_in_val [4];
  logic [MIN16_IDX_W-1:0]   w_l3_in_idx [4];
  logic [W-1:0]             w_l3_val    [2];
  logic [MIN16_IDX_W-1:0]   w_l3_idx    [2];
  logic [W-1:0]             w_root_val;
  logic [MIN16_IDX_W-1:0]   w_root_idx;
  logic                     w_stage_valid;

  for (genvar g = 0; g < 16; g++) begin : g_leaf
    assign w_l0_val[g] = min_array[g*W +: W];
    assign w_l0_idx[g] = min16_leaf_idx(g);
  end

  for (genvar g = 0; g < 8; g++) begin : g_l1
    min_2_sel #(.VAL_W(W)) u_sel (
      .i_a_val(w_l0_val[2*g]),   .i_a_idx(w_l0_idx[2*g]),
      .i_b_val(w_l0_val[2*g+1]), .i_b_idx(w_l0_idx[2*g+1]),
      .o_val  (w_l1_val[g]),     .o_idx  (w_l1_idx[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_l2
    min_2_sel #(.VAL_W(W)) u_sel (
      .i_a_val(w_l1_val[2*g]),   .i_a_idx(w_l1_idx[2*g]),
      .i_b_val(w_l1_val[2*g+1]), .i_b_idx(w_l1_idx[2*g+1]),
      .o_val  (w_l2_val[g]),     .o_idx  (w_l2_idx[g])
    );
  end

`ifdef MIN_16_PIPE_EN
  logic [W-1:0]           r_mid_val [4];
  logic [MIN16_IDX_W-1:0] r_mid_idx [4];
  logic                   r_mid_valid;

  // NOTE: the mid-tree stage is reset like any other register so a reset
  // drops in-flight sets instead of letting stale survivors emerge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_mid_val[k] <= '0;
        r_mid_idx[k] <= '0;
      end
      r_mid_valid <= 1'b0;
    end else begin
      r_mid_valid <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < 4; k++) begin
          r_mid_val[k] <= w_l2_val[k];
          r_mid_idx[k] <= w_l2_idx[k];
        end
      end
    end
  end

  assign w_l3_in_val   = r_mid_val;
  assign w_l3_in_idx   = r_mid_idx;
  assign w_stage_valid = r_mid_valid;
`else
  assign w_l3_in_val   = w_l2_val;
  assign w_l3_in_idx   = w_l2_idx;
  assign w_stage_valid = in_valid;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_l3
    min_2_sel #(.VAL_W(W)) u_sel (
      .i_a_val(w_l3_in_val[2*g]),   .i_a_idx(w_l3_in_idx[2*g]),
      .i_b_val(w_l3_in_val[2*g+1]), .i_b_idx(w_l3_in_idx[2*g+1]),
      .o_val  (w_l3_val[g]),        .o_idx  (w_l3_idx[g])
    );
  end

  min_2_sel #(.VAL_W(W)) u_root (
    .i_a_val(w_l3_val[0]), .i_a_idx(w_l3_idx[0]),
    .i_b_val(w_l3_val[1]), .i_b_idx(w_l3_idx[1]),
    .o_val  (w_root_val),  .o_idx  (w_root_idx)
  );

  // NOTE: the result registers simply skip the update when no set arrives;
  // inside always_ff that is a clock-enabled flop, not a latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min       <= '0;
      min_index <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_stage_valid;
      if (w_stage_valid) begin
        min       <= w_root_val;
        min_index <= w_root_idx;
      end
    end
  end

endmodule

// File: tb/tb_min_16.sv
// -----------------------------------------------------------------------------
// tb_min_16
// Self-checking bench for min_16: directed vector table, back-to-back
// streaming, asynchronous mid-operation reset and random sets against a
// linear-scan reference model. Build with MIN_16_PIPE_EN for the 2-cycle
// configuration.
// -----------------------------------------------------------------------------
module tb_min_16;

  localparam int W     = 14;
  localparam int ARR_W = W * 16;
`ifdef MIN_16_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [ARR_W-1:0] min_array = '0;
  logic [W-1:0]     min;
  logic [3:0]       min_index;
  logic             out_valid;

  int n_vec = 0;
  int n_err = 0;

  min_16 #(.ELEMENT_BIT_DEPTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .min_array(min_array),
    .min      (min),
    .min_index(min_index),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [ARR_W-1:0] arr;
    logic [W-1:0]     m;
    logic [3:0]       ix;
  } vec_t;

  typedef struct {
    logic             v;
    logic [ARR_W-1:0] a;
  } drv_t;

  vec_t tbl [6];

  // Reference-model state for the cycle-stepped random phase.
  drv_t         pend [$];
  drv_t         last_drv;
  logic         e_v;
  logic [W-1:0] e_m;
  logic [3:0]   e_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: linear scan, first (lowest-index) strict minimum wins.
  task automatic ref_min(input logic [ARR_W-1:0] a, output logic [W-1:0] m, output logic [3:0] ix);
    m  = a[W-1:0];
    ix = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (a[i*W +: W] < m) begin
        m  = a[i*W +: W];
        ix = 4'(i);
      end
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic [ARR_W-1:0] arr,
                         input logic [W-1:0] m, input logic [3:0] ix);
    tbl[i].name = name;
    tbl[i].arr  = arr;
    tbl[i].m    = m;
    tbl[i].ix   = ix;
  endtask

  function automatic logic [ARR_W-1:0] rand_set();
    logic [ARR_W-1:0] a;
    logic             tie_heavy;
    tie_heavy = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < 16; i++) begin
      if (tie_heavy) a[i*W +: W] = W'($urandom_range(0, 3));
      else           a[i*W +: W] = W'($urandom);
    end
    return a;
  endfunction

  // One cycle of the random phase: advance the model by what was driven last
  // cycle, compare outputs, then drive the next input.
  task automatic step(input logic v, input logic [ARR_W-1:0] a);
    drv_t         d;
    logic [W-1:0] m;
    logic [3:0]   ix;
    @(negedge clk);
    pend.push_back(last_drv);
    while (pend.size() >= LAT) begin
      d = pend.pop_front();
      if (d.v) begin
        ref_min(d.a, m, ix);
        e_m = m;
        e_i = ix;
      end
      e_v = d.v;
    end
    check("rnd_valid", 32'(out_valid), 32'(e_v));
    check("rnd_min",   32'(min),       32'(e_m));
    check("rnd_index", 32'(min_index), 32'(e_i));
    in_valid   = v;
    min_array  = a;
    last_drv.v = v;
    last_drv.a = a;
  endtask

  initial begin
    int s_sel [3];

    set_vec(0, "mixed",
            {14'h1769, 14'h1d82, 14'h1c68, 14'h1f4d, 14'h1286, 14'h1bd8, 14'h16b7, 14'h1fb3,
             14'h1c98, 14'h1ef9, 14'h17c9, 14'h196b, 14'h1ea6, 14'h1d59, 14'h17b9, 14'h1875},
            14'h1286, 4'd11);
    set_vec(1, "tie_all", {16{14'h0100}}, 14'h0100, 4'd0);
    set_vec(2, "tie_7_3",
            {{8{14'h3FFF}}, 14'h0005, {3{14'h3FFF}}, 14'h0005, {3{14'h3FFF}}},
            14'h0005, 4'd3);
    set_vec(3, "zero_e15", {14'h0000, {15{14'h3FFF}}}, 14'h0000, 4'd15);
    set_vec(4, "all_max", {16{14'h3FFF}}, 14'h3FFF, 4'd0);
    set_vec(5, "tie_15_14", {14'h0001, 14'h0001, {14{14'h3FFF}}}, 14'h0001, 4'd14);

    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    check("por_min",   32'(min),       32'h0);
    check("por_index", 32'(min_index), 32'h0);
    check("por_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed vectors, one at a time, each followed by an idle cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      min_array = tbl[i].arr;
      @(negedge clk);
      in_valid  = 1'b0;
      min_array = ~tbl[i].arr;
      repeat (LAT - 1) @(negedge clk);
      check({tbl[i].name, "_min"},   32'(min),       32'(tbl[i].m));
      check({tbl[i].name, "_index"}, 32'(min_index), 32'(tbl[i].ix));
      check({tbl[i].name, "_valid"}, 32'(out_valid), 32'h1);
      @(negedge clk);
      check({tbl[i].name, "_idle_valid"}, 32'(out_valid), 32'h0);
      check({tbl[i].name, "_hold_min"},   32'(min),       32'(tbl[i].m));
      check({tbl[i].name, "_hold_index"}, 32'(min_index), 32'(tbl[i].ix));
    end

    // Streaming: three back-to-back sets, then idle.
    s_sel = '{0, 5, 1};
    for (int c = 0; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c == LAT - 1)
        check("strm_latency_valid", 32'(out_valid), 32'h0);
      if (c >= LAT && c - LAT < 3) begin
        check("strm_valid", 32'(out_valid), 32'h1);
        check("strm_min",   32'(min),       32'(tbl[s_sel[c-LAT]].m));
        check("strm_index", 32'(min_index), 32'(tbl[s_sel[c-LAT]].ix));
      end
      if (c == LAT + 3) begin
        check("strm_end_valid", 32'(out_valid), 32'h0);
        check("strm_end_min",   32'(min),       32'(tbl[s_sel[2]].m));
        check("strm_end_index", 32'(min_index), 32'(tbl[s_sel[2]].ix));
      end
      if (c < 3) begin
        in_valid  = 1'b1;
        min_array = tbl[s_sel[c]].arr;
      end else begin
        in_valid  = 1'b0;
        min_array = rand_set();
      end
    end

    // Asynchronous reset mid-cycle, with a set in flight.
    @(negedge clk);
    in_valid  = 1'b1;
    min_array = tbl[0].arr;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_min",   32'(min),       32'h0);
    check("arst_index", 32'(min_index), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      check("arst_drop_valid", 32'(out_valid), 32'h0);
      check("arst_drop_min",   32'(min),       32'h0);
    end

    // Random phase against the reference model.
    e_v = 1'b0;
    e_m = '0;
    e_i = '0;
    last_drv.v = 1'b0;
    last_drv.a = '0;
    pend.delete();
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, rand_set());
    for (int n = 0; n < LAT + 1; n++)
      step(1'b0, rand_set());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/min_16.md
# min_16

Combinational-tree minimum finder over 16 packed unsigned elements, with registered outputs. It returns the smallest element value and its 4-bit index. It sits in the motion-estimation datapath after SAD/cost accumulation, selecting the best candidate of 16 per evaluation. A valid strobe travels alongside the data so downstream logic knows when the result is current.

## Interface
- ELEMENT_BIT_DEPTH, 14, bit width of each element and of `min`.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  `min_array` holds a new set to evaluate this cycle.
- min_array  input  ELEMENT_BIT_DEPTH*16  packed elements; element i occupies bits [i*W +: W] (W = ELEMENT_BIT_DEPTH), so element 15 is the MSB slice.
- min  output  ELEMENT_BIT_DEPTH  smallest element value, registered.
- min_index  output  4  index (0..15) of the smallest element, registered.
- out_valid  output  1  `min`/`min_index` correspond to an accepted `in_valid` set.

## Operation
- Comparison is unsigned and uses the full W bits. There is no saturation and no arithmetic; only compare and select.
- Balanced 4-level tree: 8 → 4 → 2 → 1 pairwise compare-select nodes. Each node carries a (value, index) pair; index width grows 1 → 4 bits across levels.
- Tie-break: when values are equal, the lower index wins at every node. Overall, the lowest index among equal minima is reported.
- When `in_valid` is low, the output registers hold their previous values and `out_valid` deasserts on the following edge.
- Input data is not captured in a register. The bench must hold `min_array` stable on the edge where `in_valid` is sampled.

## Timing
- Reset (async assert, sync release): `min` = 0, `min_index` = 0, `out_valid` = 0.
- Latency is 1 cycle when MIN_16_PIPE_EN is undefined:
  - `in_valid`/`min_array` are sampled on edge N.
  - The result and `out_valid` appear after edge N.
- Throughput is one set per cycle; back-to-back `in_valid` is supported with no bubbles.
- Reset asserted mid-operation clears all registers, including in-flight pipeline stages, immediately. No result is produced for sets accepted before reset.
- No backpressure; the consumer must accept results every cycle.

## Configuration
- MIN_16_PIPE_EN defined:
  - Adds a pipeline register after the 4-survivor level of the tree, holding 4 value/index pairs plus a valid bit.
  - Latency becomes 2 cycles; throughput stays one set per cycle.
  - Pipeline registers reset to 0 / invalid.
- MIN_16_PIPE_EN undefined: purely combinational tree with a single output register stage; latency 1.

## Structure
- Shared package holds:
  - `MIN16_N_ELEM` = 16.
  - `MIN16_IDX_W` = 4.
  - A helper function or typedef for a (value, index) pair, parameterised by width.
- One sub-module, `min_2_sel`:
  - Inputs: two (value, index) pairs.
  - Outputs the smaller pair, with lower-index preference on ties.
  - Instantiated 15 times via generate loops.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `min` = 0, `min_index` = 0, `out_valid` = 0 immediately.
- Mixed-value set, `in_valid` = 1. Elements 15..0 = 1769, 1d82, 1c68, 1f4d, 1286, 1bd8, 16b7, 1fb3, 1c98, 1ef9, 17c9, 196b, 1ea6, 1d59, 17b9, 1875 (hex). Required response after latency: `min` = 14'h1286, `min_index` = 11, `out_valid` = 1.
- Ties: all elements = 14'h0100 → `min` = 14'h0100, `min_index` = 0. Then only elements 7 and 3 = 14'h0005 (rest 14'h3FFF) → `min_index` = 3.
- Boundaries:
  - Element 15 = 0, rest 14'h3FFF → `min` = 0, `min_index` = 15.
  - All 14'h3FFF → `min` = 14'h3FFF, `min_index` = 0.
- Streaming: 3 back-to-back valid sets, then `in_valid` low → three results on consecutive cycles in order, then `out_valid` = 0 with `min`/`min_index` held. Repeat with MIN_16_PIPE_EN defined and check latency 2.
